framebuffer_dbuf: RTL and testbench

Double-buffered, parametrised indexed-colour framebuffer sitting between the drawing logic (writer) and the VGA scan-out (reader). Drawing always targets the back page while scan-out reads the front page; a requested page flip is applied only on the next vsync rising edge, so a frame is never shown half-drawn. Reads return palette-resolved colour through a fixed 2-cycle pipeline. An optional hardware clear engine fills the back page with one index.

---
 rtl/fb_pkg.sv | 40 ++++
 rtl/framebuffer_dbuf_if.sv | 47 ++++
 rtl/fb_clear_fsm.sv | 64 ++++++
 rtl/framebuffer_dbuf.sv | 129 ++++++++++++
 tb/tb_framebuffer_dbuf.sv | 287 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fb_pkg.sv
// Shared definitions for the double-buffered framebuffer: default geometry,
// clear-engine state encoding and the index-to-RGB444 palette lookup.
package fb_pkg;

    localparam int H_RES_DEF   = 640;
    localparam int V_RES_DEF   = 480;
    localparam int IDX_W_DEF   = 4;
    localparam int COLOR_W_DEF = 12;

    typedef enum logic [1:0] {
        CLR_IDLE,
        CLR_CLEAR,
        CLR_DONE
    } clr_state_t;

    // Palette block shared with the rest of the video path (16 entries, RGB444).
    function automatic logic [11:0] fb_palette(input logic [3:0] idx);
        logic [11:0] rgb;
        case (idx)
            4'h0:    rgb = 12'h012;
            4'h1:    rgb = 12'h00A;
            4'h2:    rgb = 12'h0A0;
            4'h3:    rgb = 12'h0AA;
            4'h4:    rgb = 12'hA00;
            4'h5:    rgb = 12'hA0A;
            4'h6:    rgb = 12'hA50;
            4'h7:    rgb = 12'hAAA;
            4'h8:    rgb = 12'h555;
            4'h9:    rgb = 12'h55F;
            4'hA:    rgb = 12'h5F5;
            4'hB:    rgb = 12'h5FF;
            4'hC:    rgb = 12'hF55;
            4'hD:    rgb = 12'hF5F;
            4'hE:    rgb = 12'hFF5;
            default: rgb = 12'hFFF;
        endcase
        return rgb;
    endfunction

endpackage

// File: rtl/framebuffer_dbuf_if.sv
// Bundle of writer, scan-out, page-flip and clear signals around the framebuffer.
// master = drawing/scan-out side, slave = framebuffer_dbuf.
interface framebuffer_dbuf_if
    import fb_pkg::*;
#(
    parameter int H_RES   = H_RES_DEF,
    parameter int V_RES   = V_RES_DEF,
    parameter int IDX_W   = IDX_W_DEF,
    parameter int COLOR_W = COLOR_W_DEF
);
    localparam int X_W = $clog2(H_RES);
    localparam int Y_W = $clog2(V_RES);

    logic               wr_valid;
    logic               wr_ready;
    logic [X_W-1:0]     wr_x;
    logic [Y_W-1:0]     wr_y;
    logic [IDX_W-1:0]   wr_index;
    logic               rd_en;
    logic [X_W-1:0]     rd_x;
    logic [Y_W-1:0]     rd_y;
    logic [COLOR_W-1:0] rd_color;
    logic               rd_valid;
    logic               vsync;
    logic               flip_req;
    logic               flip_pending;
    logic               front_page;
    logic               clear_req;
    logic [IDX_W-1:0]   clear_index;
    logic               clear_busy;
    logic               clear_done;

    modport master (
        output wr_valid, wr_x, wr_y, wr_index, rd_en, rd_x, rd_y,
               vsync, flip_req, clear_req, clear_index,
        input  wr_ready, rd_color, rd_valid, flip_pending, front_page,
               clear_busy, clear_done
    );

    modport slave (
        input  wr_valid, wr_x, wr_y, wr_index, rd_en, rd_x, rd_y,
               vsync, flip_req, clear_req, clear_index,
        output wr_ready, rd_color, rd_valid, flip_pending, front_page,
               clear_busy, clear_done
    );

endinterface

// File: rtl/fb_clear_fsm.sv
// Back-page clear engine: walks every pixel of a page once, one per cycle,
// writing the index latched at request time, then pulses done.
module fb_clear_fsm
    import fb_pkg::*;
#(
    parameter int NPIX  = H_RES_DEF * V_RES_DEF,
    parameter int LIN_W = $clog2(NPIX),
    parameter int IDX_W = IDX_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear_req,
    input  logic [IDX_W-1:0] clear_index,
    output logic             busy,
    output logic             done,
    output logic             wr_en,
    output logic [LIN_W-1:0] wr_lin,
    output logic [IDX_W-1:0] wr_index
);
    clr_state_t       state, state_nx;
    logic [LIN_W-1:0] cnt;
    logic [IDX_W-1:0] index_q;
    logic             last;

    assign last     = (cnt == LIN_W'(NPIX - 1));
    assign wr_lin   = cnt;
    assign wr_index = index_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= CLR_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            if (state == CLR_CLEAR) cnt <= last ? '0 : cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (state == CLR_IDLE && clear_req) index_q <= clear_index;
    end

    always_comb begin
        state_nx = state;
        busy     = 1'b0;
        done     = 1'b0;
        wr_en    = 1'b0;
        case (state)
            CLR_IDLE:  if (clear_req) state_nx = CLR_CLEAR;
            CLR_CLEAR: begin
                busy  = 1'b1;
                wr_en = 1'b1;
                if (last) state_nx = CLR_DONE;
            end
            CLR_DONE: begin
                busy     = 1'b1;
                done     = 1'b1;
                state_nx = CLR_IDLE;
            end
            default:   state_nx = CLR_IDLE;
        endcase
    end

endmodule

// File: rtl/framebuffer_dbuf.sv
// Double-buffered indexed-colour framebuffer with vsync-synchronised page flip
// and 2-cycle palette-resolved reads. Define FB_CLEAR_EN to build the clear engine.
module framebuffer_dbuf
    import fb_pkg::*;
#(
    parameter int H_RES   = H_RES_DEF,
    parameter int V_RES   = V_RES_DEF,
    parameter int IDX_W   = IDX_W_DEF,
    parameter int COLOR_W = COLOR_W_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    framebuffer_dbuf_if.slave  bus
);
    localparam int X_W   = $clog2(H_RES);
    localparam int Y_W   = $clog2(V_RES);
    localparam int NPIX  = H_RES * V_RES;
    localparam int LIN_W = $clog2(NPIX);
    // Page bit sits above the linear address, so each page spans a power-of-two window.
    localparam int DEPTH = 2 ** (LIN_W + 1);

    logic [IDX_W-1:0]   mem [DEPTH];
    logic               front_page_q, flip_pending_q, vsync_q, flip_edge;
    logic               clear_busy, clear_done;
    logic               clr_wr_en;
    logic [LIN_W-1:0]   clr_lin;
    logic [IDX_W-1:0]   clr_index;
    logic               wr_in, wr_en, rd_in;
    logic [LIN_W:0]     wr_addr, rd_addr;
    logic [IDX_W-1:0]   wr_data;
    logic [IDX_W-1:0]   idx_p1;
    logic               oor_p1, vld_p1, vld_p2;
    logic [COLOR_W-1:0] color_p2;

    function automatic logic [LIN_W-1:0] lin_addr(input logic [X_W-1:0] x,
                                                  input logic [Y_W-1:0] y);
        return LIN_W'(32'(y) * 32'(H_RES) + 32'(x));
    endfunction

`ifdef FB_CLEAR_EN
    fb_clear_fsm #(.NPIX(NPIX), .LIN_W(LIN_W), .IDX_W(IDX_W)) u_clear (
        .clk         (clk),
        .rst_n       (rst_n),
        .clear_req   (bus.clear_req),
        .clear_index (bus.clear_index),
        .busy        (clear_busy),
        .done        (clear_done),
        .wr_en       (clr_wr_en),
        .wr_lin      (clr_lin),
        .wr_index    (clr_index)
    );
`else
    logic unused_clear;
    assign unused_clear = &{1'b0, bus.clear_req, bus.clear_index};
    assign clear_busy   = 1'b0;
    assign clear_done   = 1'b0;
    assign clr_wr_en    = 1'b0;
    assign clr_lin      = '0;
    assign clr_index    = '0;
`endif

    assign bus.wr_ready     = ~clear_busy;
    assign bus.clear_busy   = clear_busy;
    assign bus.clear_done   = clear_done;
    assign bus.front_page   = front_page_q;
    assign bus.flip_pending = flip_pending_q;
    assign bus.rd_valid     = vld_p2;
    assign bus.rd_color     = color_p2;

    // Flip only on a vsync rising edge, never while the back page is being cleared.
    assign flip_edge = bus.vsync && !vsync_q && flip_pending_q && !clear_busy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vsync_q        <= 1'b0;
            front_page_q   <= 1'b0;
            flip_pending_q <= 1'b0;
        end else begin
            vsync_q <= bus.vsync;
            if (flip_edge) begin
                front_page_q   <= ~front_page_q;
                flip_pending_q <= 1'b0;
            end else if (bus.flip_req) begin
                flip_pending_q <= 1'b1;
            end
        end
    end

    assign wr_in = (32'(bus.wr_x) < 32'(H_RES)) && (32'(bus.wr_y) < 32'(V_RES));
    assign rd_in = (32'(bus.rd_x) < 32'(H_RES)) && (32'(bus.rd_y) < 32'(V_RES));
    assign rd_addr = {front_page_q, lin_addr(bus.rd_x, bus.rd_y)};

    always_comb begin
        wr_en   = bus.wr_valid && bus.wr_ready && wr_in;
        wr_addr = {~front_page_q, lin_addr(bus.wr_x, bus.wr_y)};
        wr_data = bus.wr_index;
        if (clr_wr_en) begin
            wr_en   = 1'b1;
            wr_addr = {~front_page_q, clr_lin};
            wr_data = clr_index;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
    end

    // p0 -> p1: RAM read, range flag travels with the data
    always_ff @(posedge clk) begin
        idx_p1 <= mem[rd_addr];
        oor_p1 <= ~rd_in;
    end

    // p1 -> p2: palette lookup into the output register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1   <= 1'b0;
            vld_p2   <= 1'b0;
            color_p2 <= '0;
        end else begin
            vld_p1 <= bus.rd_en;
            vld_p2 <= vld_p1;
            if (vld_p1)
                color_p2 <= oor_p1 ? COLOR_W'(fb_palette(4'd0))
                                   : COLOR_W'(fb_palette(4'(idx_p1)));
        end
    end

endmodule

// File: tb/tb_framebuffer_dbuf.sv
// Directed bench for framebuffer_dbuf at a 10x6 geometry (non-power-of-two so
// out-of-range coordinates are representable); clear checks under FB_CLEAR_EN.
module tb_framebuffer_dbuf;
    localparam int H = 10;
    localparam int V = 6;
    localparam int N = H * V;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    framebuffer_dbuf_if #(.H_RES(H), .V_RES(V), .IDX_W(4), .COLOR_W(12)) bus ();

    framebuffer_dbuf #(.H_RES(H), .V_RES(V), .IDX_W(4), .COLOR_W(12)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int         n_chk = 0;
    int         n_bad = 0;
    int         front = 0;
    logic [11:0] pal [16];
    logic [3:0]  model [2][N];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_px(input int x, input int y, input logic [3:0] idx);
        bus.wr_valid = 1'b1;
        bus.wr_x     = 4'(x);
        bus.wr_y     = 3'(y);
        bus.wr_index = idx;
        for (int i = 0; i < 200; i++) begin
            if (bus.wr_ready) break;
            tick();
        end
        if (!bus.wr_ready) chk("wr_ready_wait", bus.wr_ready, 1);
        tick();
        bus.wr_valid = 1'b0;
        if (x < H && y < V) model[1-front][y*H+x] = idx;
    endtask

    task automatic read_px(input string tag, input int x, input int y, input logic [11:0] exp);
        bus.rd_en = 1'b1;
        bus.rd_x  = 4'(x);
        bus.rd_y  = 3'(y);
        tick();
        bus.rd_en = 1'b0;
        chk({tag, "_lat1"}, bus.rd_valid, 0);
        tick();
        chk({tag, "_lat2"}, bus.rd_valid, 1);
        chk(tag, bus.rd_color, exp);
    endtask

    task automatic read_page(input string tag);
        for (int k = 0; k <= N; k++) begin
            if (k < N) begin
                bus.rd_en = 1'b1;
                bus.rd_x  = 4'(k % H);
                bus.rd_y  = 3'(k / H);
            end else begin
                bus.rd_en = 1'b0;
            end
            tick();
            if (k >= 1) chk(tag, {bus.rd_valid, bus.rd_color}, {1'b1, pal[model[front][k-1]]});
        end
    endtask

    task automatic flip_pulse();
        bus.flip_req = 1'b1;
        tick();
        bus.flip_req = 1'b0;
    endtask

    task automatic vsync_pulse();
        bus.vsync = 1'b1;
        tick();
        bus.vsync = 1'b0;
        tick();
    endtask

    task automatic do_flip();
        flip_pulse();
        vsync_pulse();
        front = 1 - front;
    endtask

    initial begin
        #200000;
        n_bad++;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        pal = '{12'h012, 12'h00A, 12'h0A0, 12'h0AA, 12'hA00, 12'hA0A, 12'hA50, 12'hAAA,
                12'h555, 12'h55F, 12'h5F5, 12'h5FF, 12'hF55, 12'hF5F, 12'hFF5, 12'hFFF};
        bus.wr_valid = 0; bus.wr_x = 0; bus.wr_y = 0; bus.wr_index = 0;
        bus.rd_en = 0; bus.rd_x = 0; bus.rd_y = 0;
        bus.vsync = 0; bus.flip_req = 0; bus.clear_req = 0; bus.clear_index = 0;

        #2 rst_n = 1'b0;
        tick(); tick();
        chk("rst_wr_ready", bus.wr_ready, 1);
        chk("rst_front", bus.front_page, 0);
        chk("rst_pending", bus.flip_pending, 0);
        chk("rst_rd_valid", bus.rd_valid, 0);
        chk("rst_rd_color", bus.rd_color, 0);
        chk("rst_busy", bus.clear_busy, 0);
        chk("rst_done", bus.clear_done, 0);
        rst_n = 1'b1;
        tick();

        // Fill page 1, show it, then fill page 0 with known content.
        for (int k = 0; k < N; k++) write_px(k % H, k / H, 4'((k * 7 + 3) & 15));
        flip_pulse();
        chk("flip1_pending", bus.flip_pending, 1);
        vsync_pulse();
        front = 1;
        chk("flip1_front", bus.front_page, 1);
        chk("flip1_cleared", bus.flip_pending, 0);
        for (int k = 0; k < N; k++) write_px(k % H, k / H, 4'((k * 5 + 1) & 15));
        write_px(0, 0, 4'd5);
        write_px(9, 5, 4'd9);

        // Out-of-range writes handshake and are dropped.
        bus.wr_valid = 1'b1; bus.wr_x = 4'd10; bus.wr_y = 3'd0; bus.wr_index = 4'hE;
        chk("oor_ready_x10", bus.wr_ready, 1);
        tick();
        bus.wr_x = 4'd15; bus.wr_y = 3'd7;
        chk("oor_ready_x15", bus.wr_ready, 1);
        tick();
        bus.wr_x = 4'd3; bus.wr_y = 3'd6;
        chk("oor_ready_y6", bus.wr_ready, 1);
        tick();
        bus.wr_valid = 1'b0;

        do_flip();
        chk("flip2_front", bus.front_page, 0);
        read_px("rd_0_0", 0, 0, 12'hA0A);
        read_px("rd_9_5", 9, 5, 12'h55F);
        read_page("pg0_readback");
        read_px("rd_oor", 12, 2, 12'h012);

        // Flip makes the freshly drawn back page visible only at the vsync edge.
        write_px(3, 2, 4'd3);
        read_px("pre_flip", 3, 2, 12'hA00);
        flip_pulse();
        chk("pend_before_edge", bus.flip_pending, 1);
        chk("front_before_edge", bus.front_page, 0);
        bus.vsync = 1'b1;
        tick();
        chk("front_at_edge", bus.front_page, 1);
        chk("pend_at_edge", bus.flip_pending, 0);
        bus.vsync = 1'b0;
        tick();
        front = 1;
        read_px("post_flip", 3, 2, 12'h0AA);

        // Two requests in one frame give a single toggle.
        flip_pulse();
        tick();
        flip_pulse();
        bus.vsync = 1'b1;
        tick();
        chk("dbl_front", bus.front_page, 0);
        chk("dbl_pending", bus.flip_pending, 0);
        bus.vsync = 1'b0;
        tick();
        vsync_pulse();
        chk("dbl_no_second", bus.front_page, 0);
        front = 0;

        // Request while vsync already high waits for the next rising edge.
        bus.vsync = 1'b1;
        tick();
        flip_pulse();
        tick();
        chk("hold_front", bus.front_page, 0);
        chk("hold_pending", bus.flip_pending, 1);
        bus.vsync = 1'b0;
        tick();
        bus.vsync = 1'b1;
        tick();
        chk("hold_edge_front", bus.front_page, 1);
        bus.vsync = 1'b0;
        tick();
        front = 1;

        // Write in the flip cycle lands in the page that becomes visible.
        flip_pulse();
        bus.wr_valid = 1'b1; bus.wr_x = 4'd4; bus.wr_y = 3'd4; bus.wr_index = 4'hB;
        bus.vsync = 1'b1;
        tick();
        bus.wr_valid = 1'b0;
        bus.vsync = 1'b0;
        tick();
        model[0][44] = 4'hB;
        front = 0;
        chk("wrflip_front", bus.front_page, 0);
        read_px("wr_flip", 4, 4, 12'h5FF);

`ifdef FB_CLEAR_EN
        begin
            int busy_cyc;
            int done_cyc;
            int done_n;
            busy_cyc = 0; done_cyc = 0; done_n = 0;
            bus.clear_index = 4'd7;
            bus.clear_req   = 1'b1;
            tick();
            bus.clear_req = 1'b0;
            chk("clr_busy_rise", bus.clear_busy, 1);
            chk("clr_wr_ready", bus.wr_ready, 0);
            for (int i = 1; i <= 200; i++) begin
                if (!bus.clear_busy) break;
                busy_cyc++;
                if (bus.clear_done) begin
                    done_n++;
                    done_cyc = i;
                end
                bus.flip_req = (i == 3);
                bus.vsync    = (i == 10);
                tick();
            end
            bus.flip_req = 1'b0;
            bus.vsync    = 1'b0;
            chk("clr_busy_cycles", busy_cyc, N + 1);
            chk("clr_done_cycle", done_cyc, N + 1);
            chk("clr_done_pulses", done_n, 1);
            chk("clr_no_flip", bus.front_page, 0);
            chk("clr_pending", bus.flip_pending, 1);
            chk("clr_ready_back", bus.wr_ready, 1);
            vsync_pulse();
            front = 1;
            chk("clr_flip_front", bus.front_page, 1);
            for (int k = 0; k < N; k++) model[1][k] = 4'd7;
            read_page("clr_page");
        end
        bus.clear_index = 4'd2;
        bus.clear_req   = 1'b1;
        tick();
        bus.clear_req = 1'b0;
        chk("pre_rst_busy", bus.clear_busy, 1);
`else
        do_flip();
`endif
        chk("pre_rst_front", bus.front_page, 1);
        bus.flip_req = 1'b1;
        bus.rd_en = 1'b1; bus.rd_x = 4'd0; bus.rd_y = 3'd0;
        tick();
        bus.flip_req = 1'b0;
        bus.rd_en = 1'b0;
        tick();
        chk("pre_rst_vld", bus.rd_valid, 1);
        chk("pre_rst_pending", bus.flip_pending, 1);
        rst_n = 1'b0;
        #1;
        chk("arst_busy", bus.clear_busy, 0);
        chk("arst_done", bus.clear_done, 0);
        chk("arst_wr_ready", bus.wr_ready, 1);
        chk("arst_front", bus.front_page, 0);
        chk("arst_pending", bus.flip_pending, 0);
        chk("arst_rd_valid", bus.rd_valid, 0);
        chk("arst_rd_color", bus.rd_color, 0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("post_rst_ready", bus.wr_ready, 1);
        chk("post_rst_front", bus.front_page, 0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
